// File: rtl/menu_text_buffer.sv
// Character cell buffer for a menu display: one synchronous read port, one write port,
// a hardware clear sweep, and a wrapping menu selection that drives row highlighting.
module menu_text_buffer #(
    parameter int                COLS        = 16,
    parameter int                ROWS        = 16,
    parameter int                CODE_W      = 7,
    parameter logic [CODE_W-1:0] FILL        = 7'h20,
    parameter int                MENU_ITEMS  = 2,
    parameter int                MENU_ROW0   = 0,
    parameter int                MENU_STRIDE = 2,
    localparam int               CB          = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int               RB          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int               SB          = (MENU_ITEMS > 1) ? $clog2(MENU_ITEMS) : 1,
    localparam int               AW          = RB + CB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     char_xy,
    output logic [CODE_W-1:0] code,
    output logic              highlight,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_xy,
    input  logic [CODE_W-1:0] wr_code,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              busy,
    input  logic              sel_up,
    input  logic              sel_down,
    output logic [SB-1:0]     sel_row
);

    localparam int DEPTH = COLS * ROWS;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    logic [IW-1:0]     clr_cnt_r;
    logic [CODE_W-1:0] mem_r [DEPTH];

    logic [RB-1:0]     rd_row_s;
    logic [CB-1:0]     rd_col_s;
    logic              rd_ok_s;
    logic [IW-1:0]     rd_idx_s;
    logic              rd_hl_s;
    int                hl_row_s;
    logic [RB-1:0]     wr_row_s;
    logic [CB-1:0]     wr_col_s;
    logic              wr_ok_s;
    logic [IW-1:0]     wr_idx_s;
    logic              mem_we_s;
    logic [IW-1:0]     mem_addr_s;
    logic [CODE_W-1:0] mem_data_s;

    assign busy     = (state_r == CLEAR);
    assign wr_ready = (state_r == IDLE) && !rst;

    // Address decode for both ports and the highlighted-row match.
    always_comb begin
        rd_row_s = char_xy[AW-1:CB];
        rd_col_s = char_xy[CB-1:0];
        rd_ok_s  = (int'(rd_row_s) < ROWS) && (int'(rd_col_s) < COLS);
        rd_idx_s = IW'(int'(rd_row_s) * COLS + int'(rd_col_s));
        hl_row_s = MENU_ROW0 + int'(sel_row) * MENU_STRIDE;
        rd_hl_s  = rd_ok_s && (int'(rd_row_s) == hl_row_s);
        wr_row_s = wr_xy[AW-1:CB];
        wr_col_s = wr_xy[CB-1:0];
        wr_ok_s  = (int'(wr_row_s) < ROWS) && (int'(wr_col_s) < COLS);
        wr_idx_s = IW'(int'(wr_row_s) * COLS + int'(wr_col_s));
    end

    // Write-port arbitration: the sweep owns the port while clearing; user writes are dropped then.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = wr_idx_s;
        mem_data_s = wr_code;
        if (state_r == CLEAR) begin
            mem_we_s   = !rst;
            mem_addr_s = clr_cnt_r;
            mem_data_s = FILL;
        end else begin
            mem_we_s   = !rst && wr_en && wr_ok_s;
            mem_addr_s = wr_idx_s;
            mem_data_s = wr_code;
        end
    end

    // Storage array; left unreset because the post-reset sweep blanks every cell.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // Control FSM, selection register and registered read outputs (read-before-write via NBA).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= CLEAR;
            clr_cnt_r <= IW'(0);
            sel_row   <= SB'(0);
            code      <= FILL;
            highlight <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clr_start) begin
                        state_r   <= CLEAR;
                        clr_cnt_r <= IW'(0);
                    end
                end
                CLEAR: begin
                    if (clr_cnt_r == IW'(DEPTH - 1)) begin
                        state_r   <= IDLE;
                        clr_cnt_r <= IW'(0);
                    end else begin
                        clr_cnt_r <= clr_cnt_r + IW'(1);
                    end
                end
                default: begin
                    state_r   <= CLEAR;
                    clr_cnt_r <= IW'(0);
                end
            endcase

            if (sel_up && !sel_down) begin
                sel_row <= (sel_row == SB'(0)) ? SB'(MENU_ITEMS - 1) : sel_row - SB'(1);
            end else if (sel_down && !sel_up) begin
                sel_row <= (sel_row == SB'(MENU_ITEMS - 1)) ? SB'(0) : sel_row + SB'(1);
            end

            if ((state_r == CLEAR) || !rd_ok_s) begin
                code <= FILL;
            end else begin
                code <= mem_r[rd_idx_s];
            end
            highlight <= (state_r == IDLE) && rd_hl_s;
        end
    end

endmodule

// File: doc/menu_text_buffer.md
MENU_TEXT_BUFFER -- requirements
Module: menu_text_buffer

Interface
REQ-001 Parameter COLS, default 16, character columns per row.
REQ-002 Parameter ROWS, default 16, character rows.
REQ-003 Parameter CODE_W, default 7, character code width (ASCII).
REQ-004 Parameter FILL, default 7'h20, blank code used for clear, out-of-range reads and busy reads.
REQ-005 Parameter MENU_ITEMS, default 2, number of selectable menu rows.
REQ-006 Parameter MENU_ROW0 / MENU_STRIDE, default 0 / 2, row of item 0 and row spacing between items.
REQ-007 Derived: CB = $clog2(COLS), RB = $clog2(ROWS), SB = $clog2(MENU_ITEMS) (min 1), AW = RB+CB.
REQ-008 clk  in  1  single system clock; all logic rising-edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 char_xy  in  AW  read address {row[RB-1:0], col[CB-1:0]}.
REQ-011 code  out  CODE_W  registered character code for char_xy.
REQ-012 highlight  out  1  registered; 1 when the read row is the selected menu row.
REQ-013 wr_en / wr_xy / wr_code  in  1 / AW / CODE_W  write request, address, data.
REQ-014 wr_ready  out  1  write accepted when wr_en && wr_ready at a clock edge.
REQ-015 clr_start  in  1  pulse: blank whole buffer.
REQ-016 busy  out  1  clear sweep in progress.
REQ-017 sel_up / sel_down  in  1  single-cycle pulses moving menu selection.
REQ-018 sel_row  out  SB  current selected item index.

Function
REQ-019 Storage SHALL be COLS*ROWS cells of CODE_W bits, single write port, single synchronous read port.
REQ-020 Read latency SHALL be exactly 1 cycle: code and highlight at edge N+1 reflect char_xy sampled at edge N.
REQ-021 A read with col >= COLS or row >= ROWS SHALL return FILL and highlight=0.
REQ-022 Reading the address written in the same cycle SHALL return the old content (read-before-write).
REQ-023 States SHALL be IDLE and CLEAR; wr_ready = (state==IDLE) && !rst; busy = (state==CLEAR).
REQ-024 IDLE->CLEAR on clr_start; clr_start while in CLEAR SHALL be ignored (no restart).
REQ-025 CLEAR SHALL write FILL to one cell per cycle, counter 0..COLS*ROWS-1 in address order, then return to IDLE; sweep length COLS*ROWS cycles (256 by default).
REQ-026 While busy, wr_en SHALL be dropped (not queued) and reads SHALL return FILL, highlight=0.
REQ-027 Writes to out-of-range wr_xy SHALL be accepted (wr_ready honoured) and discarded.
REQ-028 sel_up SHALL decrement sel_row, wrapping 0 -> MENU_ITEMS-1; sel_down SHALL increment, wrapping MENU_ITEMS-1 -> 0.
REQ-029 sel_up and sel_down asserted together SHALL leave sel_row unchanged.
REQ-030 Selection SHALL update in any state, including CLEAR.
REQ-031 highlight SHALL be 1 when read row == MENU_ROW0 + sel_row*MENU_STRIDE (sel_row sampled same edge as char_xy), col in range, not busy.

Reset
REQ-032 On rst: state=CLEAR, counter=0, sel_row=0, code=FILL, highlight=0, busy=1 the cycle after, wr_ready=0 while rst high.
REQ-033 After rst deasserts, the sweep SHALL complete (COLS*ROWS cycles) before wr_ready rises; buffer content after reset is all FILL.
REQ-034 rst asserted mid-sweep SHALL restart the counter at 0.

Verification
REQ-035 Reset, wait: busy high 256 cycles then low, wr_ready=1; read every address -> 7'h20, highlight=0 except row 0.
REQ-036 Write 7'h53 to 8'h00, 7'h4D to 8'h20; read 8'h00 -> 7'h53 with highlight=1 one cycle later; read 8'h20 -> 7'h4D, highlight=0.
REQ-037 sel_down once: sel_row=1; read 8'h20 -> highlight=1; sel_down again -> sel_row=0; sel_up from 0 -> 1; both pulses same cycle -> unchanged.
REQ-038 Same-cycle write 7'h41 and read of 8'h05 holding 7'h20 -> code 7'h20; next read -> 7'h41.
REQ-039 clr_start after writes: write during busy dropped, reads return 7'h20; second clr_start at cycle 100 ignored (sweep ends at 256); all cells 7'h20 after.
REQ-040 rst pulse at sweep cycle 50 -> busy stays high, full 256-cycle sweep from address 0, sel_row=0.
